// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard : XLEN x NREGS register file, async read, pending-write
// scoreboard. Optional macro REGFILE_BYPASS_EN adds writeback forwarding.
// Rev 1.0
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            RegWrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] writeData,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_rd,
  output logic [AW:0]     busy_cnt
);

  logic            w_wr_en;
  logic            w_rsv_en;
  logic            w_cnt_inc;
  logic            w_cnt_dec;
  logic            w_byp1;
  logic            w_byp2;
  logic [XLEN-1:0] w_rf [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;

  assign w_wr_en  = RegWrite  && (rd != '0);
  assign w_rsv_en = rsv_valid && (rsv_rd != '0);
  assign w_rf[0]  = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic [XLEN-1:0] data_q, data_d;

    always_comb begin
      data_d = data_q;
      if (w_wr_en && (rd == AW'(i))) data_d = writeData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
    end

    assign w_rf[i] = data_q;
  end

  // Reserve is applied after write so a same-index collision leaves busy set.
  always_comb begin
    busy_d = busy_q;
    if (w_wr_en)  busy_d[rd]     = 1'b0;
    if (w_rsv_en) busy_d[rsv_rd] = 1'b1;
    busy_d[0] = 1'b0;

    w_cnt_inc  = w_rsv_en && !busy_q[rsv_rd];
    w_cnt_dec  = w_wr_en && busy_q[rd] && !(w_rsv_en && (rsv_rd == rd));
    busy_cnt_d = busy_cnt_q + (AW+1)'(w_cnt_inc) - (AW+1)'(w_cnt_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed while reset is held so outputs read zero.
  assign w_byp1 = rst_n && w_wr_en && (rd == rs1);
  assign w_byp2 = rst_n && w_wr_en && (rd == rs2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign readData1 = w_byp1 ? writeData : w_rf[rs1];
  assign readData2 = w_byp2 ? writeData : w_rf[rs2];
  assign rs1_busy  = !w_byp1 && busy_q[rs1];
  assign rs2_busy  = !w_byp2 && busy_q[rs2];
  assign busy_cnt  = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// tb_regfile_scoreboard : directed and randomized checks of regfile_scoreboard
// against an array-based reference model (default 64x32 and a 32x8 instance).
module tb_regfile_scoreboard;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int SXLEN  = 32;
  localparam int SNREGS = 8;
  localparam int SAW    = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1, rs2, rd, rsv_rd;
  logic            RegWrite, rsv_valid;
  logic [XLEN-1:0] writeData, readData1, readData2;
  logic            rs1_busy, rs2_busy;
  logic [AW:0]     busy_cnt;

  logic [SAW-1:0]   s_rs1, s_rs2, s_rd, s_rsv_rd;
  logic             s_RegWrite, s_rsv_valid;
  logic [SXLEN-1:0] s_writeData, s_readData1, s_readData2;
  logic             s_rs1_busy, s_rs2_busy;
  logic [SAW:0]     s_busy_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [XLEN-1:0] m_rf   [NREGS];
  bit              m_busy [NREGS];

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
    .readData1(readData1), .readData2(readData2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .RegWrite(RegWrite), .rd(rd), .writeData(writeData),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .busy_cnt(busy_cnt)
  );

  regfile_scoreboard #(.XLEN(SXLEN), .NREGS(SNREGS)) dut_small (
    .clk(clk), .rst_n(rst_n), .rs1(s_rs1), .rs2(s_rs2),
    .readData1(s_readData1), .readData2(s_readData2),
    .rs1_busy(s_rs1_busy), .rs2_busy(s_rs2_busy),
    .RegWrite(s_RegWrite), .rd(s_rd), .writeData(s_writeData),
    .rsv_valid(s_rsv_valid), .rsv_rd(s_rsv_rd), .busy_cnt(s_busy_cnt)
  );

  // ---------------- reference model ----------------
  function automatic logic fwd(input logic [AW-1:0] idx);
    return BYPASS && RegWrite && (rd != 0) && (rd == idx);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] idx);
    if (fwd(idx)) return writeData;
    if (idx == 0) return '0;
    return m_rf[idx];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] idx);
    if (fwd(idx)) return 1'b0;
    return (idx != 0) && m_busy[idx];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    foreach (m_busy[i]) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    foreach (m_rf[i]) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    RegWrite = 1'b0; rd = '0; writeData = '0;
    rsv_valid = 1'b0; rsv_rd = '0;
    s_RegWrite = 1'b0; s_rd = '0; s_writeData = '0;
    s_rsv_valid = 1'b0; s_rsv_rd = '0;
  endtask

  // Commits the current big-DUT inputs to the model, then advances one edge.
  task automatic tick();
    if (RegWrite && rd != 0) begin
      m_rf[rd]   = writeData;
      m_busy[rd] = 1'b0;
    end
    if (rsv_valid && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_total++;
    if (busy_cnt !== 6'd0 || readData1 !== 64'd0) $display("FAIL reset_state: cnt=%0d rd1=%0h want 0/0", busy_cnt, readData1);
    else n_pass++;
    n_total++;
    if (s_busy_cnt !== 4'd0) $display("FAIL reset_state_small: cnt=%0d want 0", s_busy_cnt);
    else n_pass++;

    RegWrite = 1'b1; rd = 5'd5; writeData = 64'd42;
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    tick();
    idle(); rs1 = 5'd5; rs2 = 5'd7;
    #1;
    n_total++;
    if (readData1 !== 64'd42 || rs2_busy !== 1'b1 || busy_cnt !== 6'd1)
      $display("FAIL pre_reset: rd1=%0d busy2=%0b cnt=%0d want 42/1/1", readData1, rs2_busy, busy_cnt);
    else n_pass++;

    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (readData1 !== 64'd0 || rs2_busy !== 1'b0 || busy_cnt !== 6'd0)
      $display("FAIL async_reset: rd1=%0d busy2=%0b cnt=%0d want 0/0/0", readData1, rs2_busy, busy_cnt);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_x0();
    RegWrite = 1'b1; rd = '0; writeData = 64'd999;
    rsv_valid = 1'b1; rsv_rd = '0; rs1 = '0;
    tick();
    idle();
    #1;
    n_total++;
    if (readData1 !== 64'd0 || rs1_busy !== 1'b0 || busy_cnt !== 6'd0)
      $display("FAIL x0_protect: rd1=%0d busy1=%0b cnt=%0d want 0/0/0", readData1, rs1_busy, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_rd = 5'd5; rs2 = 5'd5;
    #1;
    n_total++;
    if (rs2_busy !== 1'b0) $display("FAIL rsv_no_forward: busy2=%0b want 0", rs2_busy);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (rs2_busy !== 1'b1 || busy_cnt !== 6'd1) $display("FAIL sb_reserve: busy2=%0b cnt=%0d want 1/1", rs2_busy, busy_cnt);
    else n_pass++;
    RegWrite = 1'b1; rd = 5'd5; writeData = 64'd42;
    tick();
    idle();
    #1;
    n_total++;
    if (readData2 !== 64'd42 || rs2_busy !== 1'b0 || busy_cnt !== 6'd0)
      $display("FAIL sb_writeback: rd2=%0d busy2=%0b cnt=%0d want 42/0/0", readData2, rs2_busy, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_collision();
    rsv_valid = 1'b1; rsv_rd = 5'd3;
    tick();
    RegWrite = 1'b1; rd = 5'd3; writeData = 64'd7;
    rsv_valid = 1'b1; rsv_rd = 5'd3;
    tick();
    idle(); rs1 = 5'd3;
    #1;
    n_total++;
    if (readData1 !== 64'd7 || rs1_busy !== 1'b1 || busy_cnt !== 6'd1)
      $display("FAIL same_idx: rd1=%0d busy1=%0b cnt=%0d want 7/1/1", readData1, rs1_busy, busy_cnt);
    else n_pass++;

    RegWrite = 1'b1; rd = 5'd9; writeData = 64'd1;
    rsv_valid = 1'b1; rsv_rd = 5'd4;
    tick();
    idle(); rs1 = 5'd9; rs2 = 5'd4;
    #1;
    n_total++;
    if (readData1 !== 64'd1 || rs2_busy !== 1'b1 || busy_cnt !== 6'd2)
      $display("FAIL diff_idx: rd1=%0d busy2=%0b cnt=%0d want 1/1/2", readData1, rs2_busy, busy_cnt);
    else n_pass++;

    rsv_valid = 1'b1; rsv_rd = 5'd3;
    tick();
    idle();
    #1;
    n_total++;
    if (busy_cnt !== 6'd2) $display("FAIL re_reserve: cnt=%0d want 2", busy_cnt);
    else n_pass++;
  endtask

  task automatic test_bypass();
    rsv_valid = 1'b1; rsv_rd = 5'd6;
    tick();
    idle();
    RegWrite = 1'b1; rd = 5'd6; writeData = 64'hDEAD; rs1 = 5'd6;
    #1;
    n_total++;
    if (readData1 !== (BYPASS ? 64'hDEAD : 64'd0) || rs1_busy !== !BYPASS)
      $display("FAIL bypass_pre: rd1=%0h busy1=%0b want %0h/%0b", readData1, rs1_busy,
               BYPASS ? 64'hDEAD : 64'd0, !BYPASS);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (readData1 !== 64'hDEAD || rs1_busy !== 1'b0 || busy_cnt !== 6'd2)
      $display("FAIL bypass_post: rd1=%0h busy1=%0b cnt=%0d want dead/0/2", readData1, rs1_busy, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_sweep_small();
    logic [SXLEN-1:0] vals [SNREGS];
    for (int i = 1; i < SNREGS; i++) begin
      s_rsv_valid = 1'b1; s_rsv_rd = SAW'(i);
      tick();
    end
    idle();
    #1;
    n_total++;
    if (s_busy_cnt !== 4'd7) $display("FAIL sweep_full: cnt=%0d want 7", s_busy_cnt);
    else n_pass++;
    for (int i = 1; i < SNREGS; i++) begin
      vals[i] = $urandom;
      s_RegWrite = 1'b1; s_rd = SAW'(i); s_writeData = vals[i];
      tick();
      n_total++;
      if (s_busy_cnt !== 4'(7 - i)) $display("FAIL sweep_drain: step=%0d cnt=%0d want %0d", i, s_busy_cnt, 7 - i);
      else n_pass++;
    end
    idle();
    for (int i = 1; i < SNREGS; i++) begin
      s_rs1 = SAW'(i); s_rs2 = SAW'(SNREGS - i);
      #1;
      n_total++;
      if (s_readData1 !== vals[i] || s_readData2 !== vals[SNREGS - i] || s_rs1_busy !== 1'b0)
        $display("FAIL sweep_read: x%0d=%0h x%0d=%0h busy=%0b want %0h/%0h/0", i, s_readData1,
                 SNREGS - i, s_readData2, s_rs1_busy, vals[i], vals[SNREGS - i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int lim;
    for (int it = 0; it < 300; it++) begin
      lim       = ($urandom_range(0, 1) == 1) ? 7 : NREGS - 1;
      rs1       = AW'($urandom_range(0, lim));
      rs2       = AW'($urandom_range(0, lim));
      rd        = AW'($urandom_range(0, lim));
      rsv_rd    = AW'($urandom_range(0, lim));
      RegWrite  = ($urandom_range(0, 2) != 0);
      rsv_valid = ($urandom_range(0, 1) != 0);
      writeData = {$urandom, $urandom};
      #1;
      n_total++;
      if (readData1 !== exp_data(rs1) || readData2 !== exp_data(rs2) ||
          rs1_busy !== exp_busy(rs1) || rs2_busy !== exp_busy(rs2))
        $display("FAIL rand_read it=%0d: rd1=%0h rd2=%0h b1=%0b b2=%0b want %0h/%0h/%0b/%0b", it,
                 readData1, readData2, rs1_busy, rs2_busy,
                 exp_data(rs1), exp_data(rs2), exp_busy(rs1), exp_busy(rs2));
      else n_pass++;
      tick();
      n_total++;
      if (int'(busy_cnt) !== exp_cnt()) $display("FAIL rand_cnt it=%0d: cnt=%0d want %0d", it, busy_cnt, exp_cnt());
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_reset_midop();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (busy_cnt !== 6'd0) $display("FAIL midop_cnt: cnt=%0d want 0", busy_cnt);
    else n_pass++;
    for (int i = 0; i < NREGS; i++) begin
      rs1 = AW'(i); rs2 = AW'(NREGS - 1 - i);
      #0.1;
      n_total++;
      if (readData1 !== 64'd0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
        $display("FAIL midop_read x%0d: rd1=%0h b1=%0b b2=%0b want 0/0/0", i, readData1, rs1_busy, rs2_busy);
      else n_pass++;
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1 = '0; rs2 = '0; s_rs1 = '0; s_rs2 = '0;
    idle();
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_x0();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_sweep_small();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
